// File: rtl/pe_accumulator_if.sv
// Operand, context-swap and drain-chain signals of one systolic PE accumulator stage.
interface pe_accumulator_if #(
  parameter int unsigned MUL_W = 32,
  parameter int unsigned ACC_W = 40
);
  logic             i_en_ff;
  logic [MUL_W-1:0] i_prod;
  logic             i_valid;
  logic             i_swap;
  logic [ACC_W-1:0] i_preload;
  logic             i_shift;
  logic [ACC_W-1:0] i_chain;
  logic [ACC_W-1:0] o_acc;
  logic [ACC_W-1:0] o_chain;
  logic             o_ovf;

  modport master (
    output i_en_ff, i_prod, i_valid, i_swap, i_preload, i_shift, i_chain,
    input  o_acc, o_chain, o_ovf
  );

  modport slave (
    input  i_en_ff, i_prod, i_valid, i_swap, i_preload, i_shift, i_chain,
    output o_acc, o_chain, o_ovf
  );
endinterface

// File: rtl/pe_accumulator.sv
// Systolic PE accumulation stage with context swap and chained drain register.
// Optional macro PE_ACC_SAT_EN: clamp the add result on overflow instead of wrapping.
module pe_accumulator #(
  parameter logic        SIGNED = 1'b0,
  parameter int unsigned MUL_W  = 32,
  parameter int unsigned ACC_W  = 40
) (
  input logic              i_clk,
  input logic              i_rstn,
  pe_accumulator_if.slave  bus
);

  if (ACC_W < MUL_W) begin : g_width_check
    $error("pe_accumulator: ACC_W (%0d) must be >= MUL_W (%0d)", ACC_W, MUL_W);
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] drain_q, drain_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] ext_sx, ext_zx, addend;
  logic [ACC_W:0]   add_full;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;

  assign ext_sx = ACC_W'($signed(bus.i_prod));
  assign ext_zx = ACC_W'(bus.i_prod);

  always_comb begin
    addend   = '0;
    if (bus.i_valid) addend = SIGNED ? ext_sx : ext_zx;
    add_full = {1'b0, acc_q} + {1'b0, addend};
    if (SIGNED)
      add_ovf = (acc_q[ACC_W-1] == addend[ACC_W-1]) && (add_full[ACC_W-1] != acc_q[ACC_W-1]);
    else
      add_ovf = add_full[ACC_W];
  end

`ifdef PE_ACC_SAT_EN
  logic [ACC_W-1:0] sat_max, sat_min;
  assign sat_max = SIGNED ? {1'b0, {(ACC_W-1){1'b1}}} : '1;
  assign sat_min = {1'b1, {(ACC_W-1){1'b0}}};

  // Signed overflow direction follows the common operand sign.
  always_comb begin
    sum = add_full[ACC_W-1:0];
    if (add_ovf) sum = (SIGNED && acc_q[ACC_W-1]) ? sat_min : sat_max;
  end
`else
  assign sum = add_full[ACC_W-1:0];
`endif

  always_comb begin
    acc_d   = acc_q;
    drain_d = drain_q;
    ovf_d   = ovf_q;
    if (bus.i_en_ff) begin
      if (bus.i_swap) begin
        drain_d = sum;
        acc_d   = bus.i_preload;
        ovf_d   = add_ovf;
      end else begin
        acc_d = sum;
        ovf_d = ovf_q | add_ovf;
        if (bus.i_shift) drain_d = bus.i_chain;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      acc_q   <= '0;
      drain_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      drain_q <= drain_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_acc   = acc_q;
  assign bus.o_chain = drain_q;
  assign bus.o_ovf   = ovf_q;

endmodule
